// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like port between the inst and data requesters
// Registered grant held until address acceptance; an in-order ID FIFO steers each response back.
module sram_req_arbiter #(
  parameter int MAX_OUTST   = 2,
  parameter bit DATA_FIRST  = 1'b1,
  parameter bit PROTO_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t               state, state_nxt;
  logic                 rr;  // 1: data side wins the next simultaneous request
  logic [(1<<PW)-1:0]   id_q;
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic                 push, pop, head, room, pick_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = mem_req & mem_addr_ok;
  assign pop  = mem_data_ok & (count != '0);
  assign head = id_q[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (!push && pop)
      count_nxt = count - CW'(1);
  end

  // A new grant needs a free slot after this cycle's push/pop settle.
  assign room   = count_nxt < CW'(MAX_OUTST);
  assign pick_d = (inst_req && data_req) ? (DATA_FIRST ? 1'b1 : rr) : data_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    case (state)
      IDLE: begin
        if (room && (inst_req || data_req))
          state_nxt = pick_d ? GNT_D : GNT_I;
      end
      GNT_I: begin
        mem_req   = 1'b1;
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
        if (mem_addr_ok)
          state_nxt = (room && data_req) ? GNT_D : IDLE;
      end
      GNT_D: begin
        mem_req   = 1'b1;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
        if (mem_addr_ok)
          state_nxt = (room && inst_req) ? GNT_I : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_addr_ok = (state == GNT_I) & mem_addr_ok;
  assign data_addr_ok = (state == GNT_D) & mem_addr_ok;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_q   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rr     <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push) begin
        id_q[wr_ptr] <= (state == GNT_D);
        wr_ptr       <= ptr_inc(wr_ptr);
        rr           <= (state == GNT_I);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (PROTO_CHECK && !reset)
      assert (!(mem_data_ok && count == '0))
        else $error("sram_req_arbiter: mem_data_ok with no outstanding transaction");
  end
`endif

endmodule
